paralelo_serial_tx: RTL and testbench

- Transmit-side parallel-to-serial stage that directly feeds the serial-to-parallel receiver.
- Accepts bytes over a valid/ready handshake and shifts each one out MSB-first, one bit per clk_32f cycle.
- When no data is pending, it fills the line with the COM idle symbol so the receiver can lock.
- After reset, it sends a minimum run of COM symbols before it accepts any data.

---
 rtl/paralelo_serial_tx_if.sv | 31 +++
 rtl/paralelo_serial_tx.sv | 128 ++++++++++++
 tb/tb_paralelo_serial_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// Byte-in / bit-out bus of the parallel-to-serial transmitter.
// The producer side is the master; the transmitter is the slave.
interface paralelo_serial_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       sym_start;
    logic       data_sym;
    logic       active;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  sym_start,
        input  data_sym,
        input  active
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output sym_start,
        output data_sym,
        output active
    );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter feeding the serial-to-parallel receiver.
// Bytes are shifted out MSB-first, one bit per clk_32f cycle. When no byte
// is pending, the COM symbol fills the line so the receiver can lock.
// After reset, a run of MIN_COM COM symbols goes out before data is accepted.
module paralelo_serial_tx #(
    parameter logic [7:0]  IDLE_SYM = 8'hBC,
    parameter int unsigned MIN_COM  = 4
) (
    input logic                 clk_32f,
    input logic                 reset,
    paralelo_serial_tx_if.slave bus
);
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_COM = 4'(MIN_COM - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] shreg;
    logic [7:0] byte_buf;
    logic [2:0] bit_cnt;
    logic       buf_full;
    logic [3:0] com_cnt;
    logic       cur_is_data;

    logic       boundary;
    logic       accept;
    logic       ready;
    logic       data_out_r;
    logic       sym_start_r;
    logic       data_sym_r;
    logic       active_r;

    assign boundary = (bit_cnt == 3'd7);
    assign accept   = bus.valid_in && ready;

    // State register: INIT after reset, RUN is left only through reset.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next state: leave INIT at the end of the last mandatory COM symbol.
    always_comb begin
        next_state = state;
        if ((state == INIT) && boundary && (com_cnt == LAST_COM)) begin
            next_state = RUN;
        end
    end

    // Handshake output: a byte can be taken whenever RUN has a free buffer.
    always_comb begin
        ready = (state == RUN) && !buf_full;
    end

    // Bit position inside the current symbol and count of COMs sent in INIT.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
            com_cnt <= 4'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if ((state == INIT) && boundary) begin
                com_cnt <= com_cnt + 4'd1;
            end
        end
    end

    // Shift register load at each symbol boundary; buffer occupancy flag.
    // A byte accepted on the boundary cycle lands in the buffer only and
    // waits for the following boundary, so load and accept never collide.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            shreg       <= IDLE_SYM;
            cur_is_data <= 1'b0;
            buf_full    <= 1'b0;
        end else begin
            if (boundary) begin
                if ((state == RUN) && buf_full) begin
                    shreg       <= byte_buf;
                    cur_is_data <= 1'b1;
                    buf_full    <= 1'b0;
                end else begin
                    shreg       <= IDLE_SYM;
                    cur_is_data <= 1'b0;
                end
            end
            if (accept) begin
                buf_full <= 1'b1;
            end
        end
    end

    // Holding buffer data; its validity is tracked by buf_full alone.
    always_ff @(posedge clk_32f) begin
        if (accept) begin
            byte_buf <= bus.data_in;
        end
    end

    // Registered serial outputs; ~bit_cnt selects bit 7 down to bit 0.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            data_out_r  <= 1'b0;
            sym_start_r <= 1'b0;
            data_sym_r  <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            data_out_r  <= shreg[~bit_cnt];
            sym_start_r <= (bit_cnt == 3'd0);
            data_sym_r  <= cur_is_data;
            active_r    <= (state == RUN);
        end
    end

    assign bus.ready_out = ready;
    assign bus.data_out  = data_out_r;
    assign bus.sym_start = sym_start_r;
    assign bus.data_sym  = data_sym_r;
    assign bus.active    = active_r;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Testbench for paralelo_serial_tx: symbol-level reference model plus a
// serial monitor that reassembles transmitted data symbols.
`timescale 1ns/1ps
module tb_paralelo_serial_tx;
    localparam logic [7:0] IDLE    = 8'hBC;
    localparam int         MIN_COM = 4;
    localparam int         RUN_T   = 8 * MIN_COM;

    logic clk_32f = 1'b0;
    logic reset;

    paralelo_serial_tx_if bus ();

    paralelo_serial_tx #(
        .IDLE_SYM(IDLE),
        .MIN_COM (MIN_COM)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int tests    = 0;
    int failures = 0;

    // Reference model: edge count since reset release, the symbol on the
    // line, and the single pending byte.
    int         t = 0;
    bit         pending = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    logic [7:0] cur_sym = IDLE;
    bit         cur_data = 1'b0;
    bit         exp_ready = 1'b0;
    bit         accepted = 1'b0;
    logic [4:0] exp_vec = 5'b0;
    logic [4:0] got_vec;
    logic [7:0] sent_q[$];

    // Monitor state: rebuilds bytes from the serial line.
    logic [7:0] mon_acc = 8'h00;
    int         mon_cnt = 0;
    bit         mon_data = 1'b0;
    logic [7:0] rx_q[$];

    // One clock: advance the model at the edge, sample the DUT at negedge.
    task automatic tick();
        int  b;
        bit  running_pre;
        bit  acc;
        bit  e_dout;
        @(posedge clk_32f);
        if (!reset) begin
            t         = 0;
            pending   = 1'b0;
            cur_sym   = IDLE;
            cur_data  = 1'b0;
            exp_ready = 1'b0;
            accepted  = 1'b0;
            exp_vec   = 5'b0;
        end else begin
            acc         = bus.valid_in && exp_ready;
            t           = t + 1;
            b           = (t - 1) % 8;
            running_pre = (t - 1) >= RUN_T;
            e_dout      = cur_sym[7 - b];
            exp_vec     = {e_dout, (b == 0), cur_data, running_pre, 1'b0};
            if (t % 8 == 0) begin
                if (cur_data) sent_q.push_back(cur_sym);
                if (running_pre && pending) begin
                    cur_sym  = pend_byte;
                    cur_data = 1'b1;
                    pending  = 1'b0;
                end else begin
                    cur_sym  = IDLE;
                    cur_data = 1'b0;
                end
            end
            if (acc) begin
                pending   = 1'b1;
                pend_byte = bus.data_in;
            end
            accepted   = acc;
            exp_ready  = (t >= RUN_T) && !pending;
            exp_vec[0] = exp_ready;
        end
        @(negedge clk_32f);
        got_vec = {bus.data_out, bus.sym_start, bus.data_sym, bus.active, bus.ready_out};
        if (!reset) begin
            mon_cnt = 0;
        end else begin
            if (bus.sym_start) begin
                mon_acc  = {7'b0, bus.data_out};
                mon_cnt  = 1;
                mon_data = bus.data_sym;
            end else if (mon_cnt > 0) begin
                mon_acc = {mon_acc[6:0], bus.data_out};
                mon_cnt = mon_cnt + 1;
            end
            if (mon_cnt == 8) begin
                if (mon_data) rx_q.push_back(mon_acc);
                mon_cnt = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (got_vec !== 5'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle=%0d got=%b want=00000", i, got_vec);
            end
        end
    endtask

    task automatic test_init_com();
        logic [7:0] first_sym = 8'h00;
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'($urandom);
        for (int i = 1; i <= RUN_T + 8; i++) begin
            tick();
            if (accepted) bus.valid_in = 1'b0;
            if (i <= 8) first_sym = {first_sym[6:0], bus.data_out};
            tests++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL init_cycle t=%0d got=%b want=%b", t, got_vec, exp_vec);
            end
            if (i == RUN_T) begin
                tests++;
                if (bus.active !== 1'b0 || bus.ready_out !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL init_last_com active=%b ready=%b want 0/1", bus.active, bus.ready_out);
                end
            end
            if (i == RUN_T + 1) begin
                tests++;
                if (bus.active !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL active_rise got=%b want=1", bus.active);
                end
            end
        end
        tests++;
        if (first_sym !== IDLE) begin
            failures++;
            $display("[TB] FAIL first_com got=%h want=%h", first_sym, IDLE);
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_single_byte();
        int waited = 0;
        while (!exp_ready && waited < 20) begin
            tick();
            waited++;
        end
        bus.data_in  = 8'hA5;
        bus.valid_in = 1'b1;
        tests++;
        if (bus.ready_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ready got=%b want=1", bus.ready_out);
        end
        tick();
        bus.valid_in = 1'b0;
        tests++;
        if (bus.ready_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_buf_full ready got=%b want=0", bus.ready_out);
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            tests++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL single_cycle t=%0d got=%b want=%b", t, got_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream[3] = '{8'h01, 8'h02, 8'hFF};
        int idx = 0;
        int run = 0;
        int best = 0;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (idx < 3) bus.data_in = stream[idx];
            tick();
            if (accepted) idx++;
            if (idx == 3) bus.valid_in = 1'b0;
            run  = bus.data_sym ? run + 1 : 0;
            best = (run > best) ? run : best;
            tests++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL b2b_cycle t=%0d got=%b want=%b", t, got_vec, exp_vec);
            end
        end
        tests++;
        if (idx !== 3 || best !== 24) begin
            failures++;
            $display("[TB] FAIL b2b_run accepted=%0d data_run=%0d want 3/24", idx, best);
        end
    endtask

    task automatic test_boundary();
        int waited = 0;
        int ds_first = 0;
        int ds_second = 0;
        bus.valid_in = 1'b0;
        while (!(t % 8 == 7 && !pending && !cur_data) && waited < 40) begin
            tick();
            waited++;
        end
        bus.data_in  = 8'($urandom);
        bus.valid_in = 1'b1;
        tests++;
        if (bus.ready_out !== 1'b1 || waited >= 40) begin
            failures++;
            $display("[TB] FAIL boundary_ready got=%b want=1 waited=%0d", bus.ready_out, waited);
        end
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i < 8) ds_first += int'(bus.data_sym);
            else       ds_second += int'(bus.data_sym);
            tests++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL boundary_cycle t=%0d got=%b want=%b", t, got_vec, exp_vec);
            end
        end
        tests++;
        if (ds_first !== 0 || ds_second !== 8) begin
            failures++;
            $display("[TB] FAIL boundary_order com_data=%0d byte_data=%0d want 0/8", ds_first, ds_second);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        int ds_count = 0;
        bus.data_in  = 8'h5A;
        bus.valid_in = 1'b1;
        while (!accepted && waited < 40) begin
            tick();
            waited++;
        end
        bus.data_in = 8'h33;
        tick();
        while (!accepted && waited < 40) begin
            tick();
            waited++;
        end
        bus.valid_in = 1'b0;
        while (!(t % 8 == 4 && cur_data && pending) && waited < 60) begin
            tick();
            waited++;
        end
        tests++;
        if (waited >= 60 || cur_sym !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL midreset_setup waited=%0d sym=%h want sym 5a", waited, cur_sym);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (got_vec !== 5'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got=%b want=00000", got_vec);
        end
        reset = 1'b1;
        for (int i = 0; i < RUN_T + 8; i++) begin
            tick();
            ds_count += int'(bus.data_sym);
            tests++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL midreset_cycle t=%0d got=%b want=%b", t, got_vec, exp_vec);
            end
        end
        tests++;
        if (ds_count !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_no_data data_cycles=%0d want=0", ds_count);
        end
        foreach (rx_q[i]) begin
            tests++;
            if (rx_q[i] === 8'h33 || rx_q[i] === 8'h5A) begin
                failures++;
                $display("[TB] FAIL midreset_discard rx[%0d]=%h want neither 33 nor 5a", i, rx_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.valid_in || accepted) begin
                bus.valid_in = ($urandom % 4) != 0;
                bus.data_in  = 8'($urandom);
            end
            tick();
            tests++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL random_cycle t=%0d got=%b want=%b", t, got_vec, exp_vec);
            end
        end
        bus.valid_in = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_stream_contents();
        tests++;
        if (rx_q.size() != sent_q.size()) begin
            failures++;
            $display("[TB] FAIL stream_count got=%0d want=%0d", rx_q.size(), sent_q.size());
        end else begin
            foreach (sent_q[i]) begin
                tests++;
                if (rx_q[i] !== sent_q[i]) begin
                    failures++;
                    $display("[TB] FAIL stream_byte idx=%0d got=%h want=%h", i, rx_q[i], sent_q[i]);
                end
            end
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        test_reset();
        test_init_com();
        test_single_byte();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        test_random();
        test_stream_contents();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
